// File: rtl/prio_encoder_seq.sv
// rtl/prio_encoder_seq.sv - sequential priority encoder with pending register and valid/ready output
//
// Purpose: collects request pulses into a pending register and hands out one
// granted index at a time over a valid/ready handshake. Fixed priority
// (highest set index wins) by default; define ROUND_ROBIN_EN to use a rotating
// search pointer instead.
//
// Ports:
//   clk        in   1  rising-edge clock
//   rst_n      in   1  asynchronous active-low reset
//   en         in   1  global enable, 0 freezes all state
//   req        in   N  request bits, OR-ed into pend on each enabled edge
//   out_ready  in   1  consumer accepts out_idx
//   out_valid  out  1  out_idx holds a granted index
//   out_idx    out  W  granted request index
//   pend       out  N  pending-request register
//   none       out  1  nothing pending and nothing presented
//
// Macro: ROUND_ROBIN_EN (optional round-robin arbitration)

module prio_encoder_seq #(
  parameter int N = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [N-1:0]         req,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [$clog2(N)-1:0] out_idx,
  output logic [N-1:0]         pend,
  output logic                 none
);

  localparam int W = $clog2(N);

  logic         load;
  logic         any;
  logic [W-1:0] sel_idx;
  logic [N-1:0] clr;

  assign load = en & (~out_valid | out_ready);
  assign any  = |pend;
  assign none = ~any & ~out_valid;

`ifdef ROUND_ROBIN_EN
  logic [W-1:0] ptr;
  logic [W-1:0] lo_idx;
  logic         lo_found;
  logic [W-1:0] top_idx;

  // Downward scan from ptr with wrap: the highest set bit at or below ptr
  // wins; if none exists, the scan wraps and the highest set bit overall wins.
  always_comb begin
    lo_idx   = '0;
    lo_found = 1'b0;
    top_idx  = '0;
    for (int i = 0; i < N; i++) begin
      if (pend[i] && (W'(i) <= ptr)) begin
        lo_idx   = W'(i);
        lo_found = 1'b1;
      end
      if (pend[i]) begin
        top_idx = W'(i);
      end
    end
    sel_idx = lo_found ? lo_idx : top_idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= W'(N - 1);
    end else if (load && any) begin
      ptr <= (sel_idx == '0) ? W'(N - 1) : sel_idx - 1'b1;
    end
  end
`else
  // Fixed priority: later (higher) set bits overwrite earlier ones.
  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (pend[i]) begin
        sel_idx = W'(i);
      end
    end
  end
`endif

  // The granted bit is cleared, but a request arriving on the same edge
  // re-sets it because req is OR-ed in after the clear.
  always_comb begin
    clr = '0;
    if (load && any) begin
      clr = {{(N-1){1'b0}}, 1'b1} << sel_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend      <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
    end else if (en) begin
      pend <= (pend & ~clr) | req;
      if (load) begin
        out_valid <= any;
        if (any) begin
          out_idx <= sel_idx;
        end
      end
    end
  end

endmodule

// File: tb/tb_prio_encoder_seq.sv
// tb/tb_prio_encoder_seq.sv - directed self-checking bench for prio_encoder_seq (N=8)

module tb_prio_encoder_seq;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] req;
  logic       out_ready;
  logic       out_valid;
  logic [2:0] out_idx;
  logic [7:0] pend;
  logic       none;

  int n_checks = 0;
  int n_pass   = 0;

  prio_encoder_seq #(.N(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req       (req),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_idx   (out_idx),
    .pend      (pend),
    .none      (none)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset asserted and released between clock edges.
  task automatic do_reset();
    #2;
    rst_n     = 1'b0;
    req       = 8'h00;
    out_ready = 1'b0;
    en        = 1'b1;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic check_state(input string tag, input logic v, input logic [2:0] idx,
                             input logic [7:0] p, input logic n);
    check({tag, ".valid"}, 64'(out_valid), 64'(v));
    if (v) check({tag, ".idx"}, 64'(out_idx), 64'(idx));
    check({tag, ".pend"}, 64'(pend), 64'(p));
    check({tag, ".none"}, 64'(none), 64'(n));
  endtask

  logic [2:0] rr_seq [9];
  logic [2:0] exp_idx;

  initial begin
    rr_seq = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7};

    rst_n = 1'b0; en = 1'b0; req = 8'h00; out_ready = 1'b0;
    #3;
    check("rst.valid", 64'(out_valid), 64'd0);
    check("rst.idx",   64'(out_idx),   64'd0);
    check("rst.pend",  64'(pend),      64'd0);
    check("rst.none",  64'(none),      64'd1);
    #8;
    rst_n = 1'b1;
    en    = 1'b1;

    // Three requests drained in priority order, two-edge latency.
    req = 8'h1C; out_ready = 1'b1;
    tick(); check_state("t1.e0", 1'b0, 3'd0, 8'h1C, 1'b0);
    req = 8'h00;
    tick(); check_state("t1.e1", 1'b1, 3'd4, 8'h0C, 1'b0);
    tick(); check_state("t1.e2", 1'b1, 3'd3, 8'h04, 1'b0);
    tick(); check_state("t1.e3", 1'b1, 3'd2, 8'h00, 1'b0);
    tick(); check_state("t1.e4", 1'b0, 3'd0, 8'h00, 1'b1);

    // Backpressure holds the presented grant.
    do_reset();
    req = 8'h81; out_ready = 1'b0;
    tick(); check_state("t2.e0", 1'b0, 3'd0, 8'h81, 1'b0);
    req = 8'h00;
    tick(); check_state("t2.e1", 1'b1, 3'd7, 8'h01, 1'b0);
    tick(); check_state("t2.hold", 1'b1, 3'd7, 8'h01, 1'b0);
    out_ready = 1'b1;
    tick(); check_state("t2.e3", 1'b1, 3'd0, 8'h00, 1'b0);
    tick(); check_state("t2.e4", 1'b0, 3'd0, 8'h00, 1'b1);

    // Enable low freezes everything.
    do_reset();
    en = 1'b0; req = 8'hFF; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(); check_state("t3.frozen", 1'b0, 3'd0, 8'h00, 1'b1);
    end
    en = 1'b1;
    tick(); check_state("t3.en", 1'b0, 3'd0, 8'hFF, 1'b0);
    req = 8'h00; out_ready = 1'b0;
    tick(); check_state("t3.grant", 1'b1, 3'd7, 8'h7F, 1'b0);
    en = 1'b0; out_ready = 1'b1; req = 8'hFF;
    tick(); check_state("t3.noxfer0", 1'b1, 3'd7, 8'h7F, 1'b0);
    tick(); check_state("t3.noxfer1", 1'b1, 3'd7, 8'h7F, 1'b0);

    // Set wins over grant-clear on the same bit.
    do_reset();
    req = 8'h20; out_ready = 1'b1;
    tick(); check_state("t4.e0", 1'b0, 3'd0, 8'h20, 1'b0);
    tick(); check_state("t4.e1", 1'b1, 3'd5, 8'h20, 1'b0);
    tick(); check_state("t4.e2", 1'b1, 3'd5, 8'h20, 1'b0);
    req = 8'h00;
    tick(); check_state("t4.e3", 1'b1, 3'd5, 8'h00, 1'b0);
    tick(); check_state("t4.e4", 1'b0, 3'd0, 8'h00, 1'b1);

    // Asynchronous reset mid-operation.
    do_reset();
    req = 8'h3C; out_ready = 1'b0;
    tick(); check_state("t5.e0", 1'b0, 3'd0, 8'h3C, 1'b0);
    tick(); check_state("t5.e1", 1'b1, 3'd5, 8'h3C, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_state("t5.async", 1'b0, 3'd0, 8'h00, 1'b1);
    check("t5.idx", 64'(out_idx), 64'd0);
    #1;
    rst_n = 1'b1;

    // All requests held with consumer always ready.
    do_reset();
    req = 8'hFF; out_ready = 1'b1;
    tick(); check_state("t6.e0", 1'b0, 3'd0, 8'hFF, 1'b0);
    for (int i = 0; i < 9; i++) begin
`ifdef ROUND_ROBIN_EN
      exp_idx = rr_seq[i];
`else
      exp_idx = 3'd7;
`endif
      tick(); check_state("t6.seq", 1'b1, exp_idx, 8'hFF, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
